// File: rtl/div_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : div_unit                                                         |
// | Brief   : Iterative RV32M divider (DIV/DIVU/REM/REMU), one quotient bit    |
// |           per cycle over a restoring shift-subtract loop.                  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+

module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_ci,
    output logic o_s,
    output logic o_co
);
    assign o_s  = i_a ^ i_b ^ i_ci;
    assign o_co = (i_a & i_b) | (i_ci & (i_a ^ i_b));
endmodule

module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_calc = 2'd1;
    localparam logic [1:0] c_done = 2'd2;

    localparam logic [WIDTH-1:0] c_min  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] c_ones = {WIDTH{1'b1}};

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH:0]   r_rem;
    logic             r_neg_q;
    logic             r_neg_r;
    logic [WIDTH-1:0] r_result;

    logic             w_accept;
    logic             w_signed;
    logic             w_dvd_neg;
    logic             w_dvs_neg;
    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dvs_mag;
    logic             w_div_zero;
    logic             w_ovf;
    logic             w_special;
    logic [WIDTH-1:0] w_special_res;

    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_sub_b;
    logic [WIDTH:0]   w_trial;
    logic [WIDTH+1:0] w_carry;
    logic             w_qbit;
    logic [WIDTH:0]   w_rem_next;
    logic [WIDTH-1:0] w_quo_next;
    logic [WIDTH-1:0] w_quo_fix;
    logic [WIDTH-1:0] w_rem_fix;
    logic [WIDTH-1:0] w_calc_res;
    logic             w_unused;

    // Operand conditioning at acceptance
    assign w_accept   = start && (r_state != c_calc);
    assign w_signed   = ~op[0];
    assign w_dvd_neg  = w_signed & dividend[WIDTH-1];
    assign w_dvs_neg  = w_signed & divisor[WIDTH-1];
    assign w_dvd_mag  = w_dvd_neg ? -dividend : dividend;
    assign w_dvs_mag  = w_dvs_neg ? -divisor : divisor;
    assign w_div_zero = (divisor == '0);
    assign w_ovf      = w_signed && (dividend == c_min) && (divisor == c_ones);
    assign w_special  = w_div_zero | w_ovf;

    always_comb begin
        w_special_res = '0;
        if (w_div_zero) begin
            w_special_res = op[1] ? dividend : c_ones;
        end else begin
            w_special_res = op[1] ? '0 : c_min;
        end
    end

    // Partial remainder never exceeds 2*divisor-1, so WIDTH+1 bits cannot overflow
    assign w_shift    = {r_rem[WIDTH-1:0], r_dvd[WIDTH-1]};
    assign w_sub_b    = ~{1'b0, r_dvs};
    assign w_carry[0] = 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi <= WIDTH; gi++) begin : g_fa
            full_adder u_fa (
                .i_a  (w_shift[gi]),
                .i_b  (w_sub_b[gi]),
                .i_ci (w_carry[gi]),
                .o_s  (w_trial[gi]),
                .o_co (w_carry[gi+1])
            );
        end
    endgenerate

    // Carry out of the subtract chain means no borrow
    assign w_qbit     = w_carry[WIDTH+1];
    assign w_rem_next = w_qbit ? w_trial : w_shift;
    assign w_quo_next = {r_dvd[WIDTH-2:0], w_qbit};
    assign w_quo_fix  = r_neg_q ? -w_quo_next : w_quo_next;
    assign w_rem_fix  = r_neg_r ? -w_rem_next[WIDTH-1:0] : w_rem_next[WIDTH-1:0];
    assign w_calc_res = r_op[1] ? w_rem_fix : w_quo_fix;
    assign w_unused   = r_rem[WIDTH] ^ w_rem_next[WIDTH];

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_idle:  if (start) w_state_next = w_special ? c_done : c_calc;
            c_calc:  if (r_cnt == '0) w_state_next = c_done;
            c_done: begin
                if (start) w_state_next = w_special ? c_done : c_calc;
                else       w_state_next = c_idle;
            end
            default: w_state_next = c_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_idle;
            r_cnt    <= '0;
            r_op     <= '0;
            r_dvd    <= '0;
            r_dvs    <= '0;
            r_rem    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_result <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_op    <= op;
                r_dvd   <= w_dvd_mag;
                r_dvs   <= w_dvs_mag;
                r_rem   <= '0;
                r_cnt   <= CNT_W'(WIDTH - 1);
                r_neg_q <= w_dvd_neg ^ w_dvs_neg;
                r_neg_r <= w_dvd_neg;
                if (w_special) r_result <= w_special_res;
            end else if (r_state == c_calc) begin
                r_rem <= w_rem_next;
                r_dvd <= w_quo_next;
                r_cnt <= r_cnt - CNT_W'(1);
                if (r_cnt == '0) r_result <= w_calc_res;
            end
        end
    end

    assign busy   = (r_state == c_calc);
    assign done   = (r_state == c_done);
    assign result = r_result;

endmodule
`default_nettype wire
